// File: rtl/mc_cpu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mc_cpu_pkg : shared encodings for the multicycle MIPS-subset controller
// Rev 1.0
// ============================================================================
package mc_cpu_pkg;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [5:0] ALU_SLL  = 6'h00;
    localparam logic [5:0] ALU_SRL  = 6'h02;
    localparam logic [5:0] ALU_SRA  = 6'h03;
    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_SUB  = 6'h22;
    localparam logic [5:0] ALU_AND  = 6'h24;
    localparam logic [5:0] ALU_OR   = 6'h25;
    localparam logic [5:0] ALU_XOR  = 6'h26;
    localparam logic [5:0] ALU_NOR  = 6'h27;
    localparam logic [5:0] ALU_SLT  = 6'h2A;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REGA   = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_REGA  = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [2:0] SRCB_REGB    = 3'd0;
    localparam logic [2:0] SRCB_FOUR    = 3'd1;
    localparam logic [2:0] SRCB_SEXT    = 3'd2;
    localparam logic [2:0] SRCB_SEXT_SH = 3'd3;
    localparam logic [2:0] SRCB_ZEXT    = 3'd4;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_R_EXEC   = 4'd3,
        S_R_WB     = 4'd4,
        S_I_EXEC   = 4'd5,
        S_I_WB     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_MEM_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    // Shifts take their first operand from the shamt field, not from rs.
    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == ALU_SLL) || (fn == ALU_SRL) || (fn == ALU_SRA);
    endfunction

    function automatic logic r_alu_legal(input logic [5:0] fn);
        case (fn)
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB,
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_decode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mc_alu_decode : {state, opcode, funct} -> ALU function, operand selects, legality
// Rev 1.0
// ============================================================================
module mc_alu_decode
    import mc_cpu_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [5:0] alu_func_o,
    output logic [1:0] alu_src_a_o,
    output logic [2:0] alu_src_b_o,
    output logic       legal_o
);

    always_comb begin
        legal_o = 1'b0;
        case (opcode_i)
            OP_R:    legal_o = r_alu_legal(funct_i) || (funct_i == FN_JR);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW:
                     legal_o = 1'b1;
            default: legal_o = 1'b0;
        endcase
    end

    always_comb begin
        alu_func_o  = '0;
        alu_src_a_o = SRCA_PC;
        alu_src_b_o = SRCB_REGB;
        case (state_t'(state_i))
            S_FETCH: begin
                alu_func_o  = ALU_ADD;
                alu_src_b_o = SRCB_FOUR;
            end
            S_DECODE: begin
                alu_func_o  = ALU_ADD;
                alu_src_b_o = SRCB_SEXT_SH;
            end
            S_R_EXEC: begin
                alu_func_o  = funct_i;
                alu_src_a_o = is_shift(funct_i) ? SRCA_SHAMT : SRCA_REGA;
            end
            S_I_EXEC: begin
                alu_src_a_o = SRCA_REGA;
                case (opcode_i)
                    OP_SLTI: begin
                        alu_func_o  = ALU_SLT;
                        alu_src_b_o = SRCB_SEXT;
                    end
                    OP_ANDI: begin
                        alu_func_o  = ALU_AND;
                        alu_src_b_o = SRCB_ZEXT;
                    end
                    OP_ORI: begin
                        alu_func_o  = ALU_OR;
                        alu_src_b_o = SRCB_ZEXT;
                    end
                    OP_XORI: begin
                        alu_func_o  = ALU_XOR;
                        alu_src_b_o = SRCB_ZEXT;
                    end
                    default: begin
                        alu_func_o  = ALU_ADD;
                        alu_src_b_o = SRCB_SEXT;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_func_o  = ALU_ADD;
                alu_src_a_o = SRCA_REGA;
                alu_src_b_o = SRCB_SEXT;
            end
            S_BRANCH: begin
                alu_func_o  = ALU_SUB;
                alu_src_a_o = SRCA_REGA;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_cpu_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mc_cpu_ctrl : multicycle MIPS-subset control FSM (optional MC_CTRL_PERF_EN counters)
// Rev 1.0
// ============================================================================
module mc_cpu_ctrl
    import mc_cpu_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [5:0] alu_func,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       halt
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cyc_cnt,
    output logic [PERF_W-1:0] instr_cnt
`endif
);

    state_t state_q;
    state_t state_d;
    logic   w_legal;

    mc_alu_decode u_alu_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .funct_i     (funct),
        .alu_func_o  (alu_func),
        .alu_src_a_o (alu_src_a),
        .alu_src_b_o (alu_src_b),
        .legal_o     (w_legal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (!w_legal) begin
                    state_d = S_TRAP;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                        OP_R:           state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        default:        state_d = S_I_EXEC;
                    endcase
                end
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ack) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ack) state_d = S_FETCH;
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JR:
                        state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_RESET;
        endcase
    end

    // Async reset forces RESET at once so mem_req drops the same instant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_ALU;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        halt       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
                pc_we   = mem_ack;
            end
            S_R_WB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            S_I_WB: reg_we = 1'b1;
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mdr_we  = mem_ack;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                pc_src = PC_ALUOUT;
                pc_we  = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = PC_JUMP;
            end
            S_JR: begin
                pc_we  = 1'b1;
                pc_src = PC_REGA;
            end
            S_TRAP:  halt = 1'b1;
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] cyc_q;
    logic [PERF_W-1:0] instr_q;
    logic              w_instr_done;

    // An instruction retires on any entry to FETCH except the one out of RESET.
    assign w_instr_done = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_RESET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != S_RESET && state_q != S_TRAP) begin
                cyc_q <= cyc_q + 1'b1;
            end
            if (w_instr_done) begin
                instr_q <= instr_q + 1'b1;
            end
        end
    end

    assign cyc_cnt   = cyc_q;
    assign instr_cnt = instr_q;
`else
    logic [PERF_W-1:0] w_unused_perf;
    assign w_unused_perf = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_cpu_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mc_cpu_ctrl : trace-model bench for mc_cpu_ctrl (MC_CTRL_PERF_EN adds counter checks)
// Rev 1.0
// ============================================================================
module tb_mc_cpu_ctrl;

    localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_BEQ = 6'h04, T_BNE = 6'h05;
    localparam logic [5:0] T_ADDI = 6'h08, T_ADDIU = 6'h09, T_SLTI = 6'h0A;
    localparam logic [5:0] T_ANDI = 6'h0C, T_ORI = 6'h0D, T_XORI = 6'h0E;
    localparam logic [5:0] T_LW = 6'h23, T_SW = 6'h2B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       alu_zero = 1'b0, mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, mdr_we, pc_we, reg_we, reg_dst, mem_to_reg, halt;
    logic [1:0] pc_src, alu_src_a;
    logic [2:0] alu_src_b;
    logic [5:0] alu_func;
`ifdef MC_CTRL_PERF_EN
    logic [3:0] cyc_cnt, instr_cnt;
`endif

    mc_cpu_ctrl #(.PERF_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_func(alu_func),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halt(halt)
`ifdef MC_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
    );

    typedef struct packed {
        logic mem_req, mem_we, iord, ir_we, mdr_we, pc_we;
        logic [1:0] pc_src, src_a;
        logic [2:0] src_b;
        logic [5:0] alu_func;
        logic reg_we, reg_dst, mem_to_reg, halt;
    } outv_t;

    typedef struct packed {
        logic [5:0] op, fn;
        logic zero, ack;
    } stim_t;

    outv_t dutv;
    assign dutv = {mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pc_src, alu_src_a,
                   alu_src_b, alu_func, reg_we, reg_dst, mem_to_reg, halt};

    int    total = 0, bad = 0;
    stim_t sq[$];
    outv_t eq[$];
    outv_t obs[$];

    task automatic check_vec(input string nm, input outv_t e);
        total++;
        obs.push_back(dutv);
        if (dutv !== e) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, dutv, e);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic outv_t v_alu(input logic [5:0] f, input logic [1:0] a, input logic [2:0] b);
        outv_t v = '0;
        v.alu_func = f;
        v.src_a    = a;
        v.src_b    = b;
        return v;
    endfunction

    // 0 R-ALU, 1 imm, 2 LW, 3 SW, 4 branch, 5 J, 6 JR, 7 illegal
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            T_R: case (fn)
                6'h00, 6'h02, 6'h03, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: return 0;
                6'h08:   return 6;
                default: return 7;
            endcase
            T_ADDI, T_ADDIU, T_SLTI, T_ANDI, T_ORI, T_XORI: return 1;
            T_LW:           return 2;
            T_SW:           return 3;
            T_BEQ, T_BNE:   return 4;
            T_J:            return 5;
            default:        return 7;
        endcase
    endfunction

    function automatic outv_t imm_exec(input logic [5:0] op);
        case (op)
            T_SLTI:  return v_alu(6'h2A, 2'd1, 3'd2);
            T_ANDI:  return v_alu(6'h24, 2'd1, 3'd4);
            T_ORI:   return v_alu(6'h25, 2'd1, 3'd4);
            T_XORI:  return v_alu(6'h26, 2'd1, 3'd4);
            default: return v_alu(6'h20, 2'd1, 3'd2);
        endcase
    endfunction

    task automatic push(input stim_t s, input outv_t v);
        sq.push_back(s);
        eq.push_back(v);
    endtask

    // Appends the per-cycle stimulus and expected outputs of one instruction.
    task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw, input logic nz, input int ntrap);
        stim_t s;
        outv_t v;
        int    cls;
        s.op = op; s.fn = fn; s.zero = nz; s.ack = 1'b0;
        cls = classify(op, fn);
        for (int i = 0; i <= fw; i++) begin
            v = v_alu(6'h20, 2'd0, 3'd1);
            v.mem_req = 1'b1;
            s.ack = (i == fw);
            if (i == fw) begin
                v.ir_we = 1'b1;
                v.pc_we = 1'b1;
            end
            push(s, v);
        end
        s.ack = nz;
        push(s, v_alu(6'h20, 2'd0, 3'd3));
        case (cls)
            0: begin
                push(s, v_alu(fn, (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd1, 3'd0));
                v = '0; v.reg_we = 1'b1; v.reg_dst = 1'b1;
                push(s, v);
            end
            1: begin
                push(s, imm_exec(op));
                v = '0; v.reg_we = 1'b1;
                push(s, v);
            end
            2, 3: begin
                push(s, v_alu(6'h20, 2'd1, 3'd2));
                for (int i = 0; i <= mw; i++) begin
                    v = '0; v.mem_req = 1'b1; v.iord = 1'b1; v.mem_we = (cls == 3);
                    v.mdr_we = (cls == 2) && (i == mw);
                    s.ack = (i == mw);
                    push(s, v);
                end
                s.ack = nz;
                if (cls == 2) begin
                    v = '0; v.reg_we = 1'b1; v.mem_to_reg = 1'b1;
                    push(s, v);
                end
            end
            4: begin
                s.zero = z;
                v = v_alu(6'h22, 2'd1, 3'd0);
                v.pc_src = 2'd1;
                v.pc_we  = (op == T_BEQ) ? z : !z;
                push(s, v);
            end
            5, 6: begin
                v = '0; v.pc_we = 1'b1; v.pc_src = (cls == 5) ? 2'd2 : 2'd3;
                push(s, v);
            end
            default: begin
                for (int i = 0; i < ntrap; i++) begin
                    v = '0; v.halt = 1'b1;
                    s.ack = i[0];
                    push(s, v);
                end
            end
        endcase
    endtask

    task automatic run(input string lbl, input int n);
        int    k;
        stim_t s;
        outv_t e;
        k = (n < 0 || n > sq.size()) ? sq.size() : n;
        obs.delete();
        for (int i = 0; i < k; i++) begin
            s = sq.pop_front();
            e = eq.pop_front();
            @(posedge clk); #1;
            opcode = s.op; funct = s.fn; alu_zero = s.zero; mem_ack = s.ack;
            @(negedge clk);
            check_vec($sformatf("%s[%0d]", lbl, i), e);
        end
        sq.delete();
        eq.delete();
    endtask

    task automatic release_rst(input string lbl);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ack = 1'b1; alu_zero = 1'b1;
        @(negedge clk);
        check_vec(lbl, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_vec("rst_async", '0);
        @(negedge clk);
        check_vec("rst_hold", '0);
        release_rst("rst_release");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        check_vec("rst_init", '0);
        release_rst("rst_first");

        gen(T_R, 6'h20, 1'b0, 0, 0, 1'b1, 0);
        check_int("add_model_len", eq.size(), 4);
        run("add", -1);
        check_int("add_len", obs.size(), 4);
        check_int("add_func", obs[2].alu_func, 6'h20);
        check_int("add_wb", {obs[3].reg_we, obs[3].reg_dst, obs[3].mem_to_reg}, 3'b110);

        gen(T_LW, 6'h11, 1'b0, 0, 2, 1'b0, 0);
        run("lw", -1);
        n = 0;
        foreach (obs[i]) if (obs[i].mem_req && obs[i].iord) n++;
        check_int("lw_len", obs.size(), 7);
        check_int("lw_memreq", n, 3);
        n = 0;
        foreach (obs[i]) if (obs[i].mdr_we) n++;
        check_int("lw_mdr", n, 1);

        gen(T_BEQ, 6'h00, 1'b1, 0, 0, 1'b0, 0);
        run("beq1", -1);
        check_int("beq_pc", {obs[2].pc_we, obs[2].pc_src}, 3'b101);
        gen(T_BNE, 6'h00, 1'b1, 0, 0, 1'b0, 0);
        run("bne1", -1);
        check_int("bne_pcwe", obs[2].pc_we, 0);
        gen(T_R, 6'h00, 1'b0, 0, 0, 1'b1, 0);
        run("sll", -1);
        check_int("sll_srca", obs[2].src_a, 2);

        gen(T_SW,    6'h3F, 1'b0, 1, 1, 1'b1, 0);
        gen(T_R,     6'h22, 1'b0, 0, 0, 1'b0, 0);
        gen(T_R,     6'h24, 1'b0, 2, 0, 1'b1, 0);
        gen(T_R,     6'h25, 1'b0, 0, 0, 1'b0, 0);
        gen(T_R,     6'h26, 1'b0, 0, 0, 1'b1, 0);
        gen(T_R,     6'h27, 1'b0, 0, 0, 1'b0, 0);
        gen(T_R,     6'h2A, 1'b0, 0, 0, 1'b1, 0);
        gen(T_R,     6'h02, 1'b0, 0, 0, 1'b0, 0);
        gen(T_R,     6'h03, 1'b0, 0, 0, 1'b1, 0);
        gen(T_ADDI,  6'h20, 1'b0, 0, 0, 1'b1, 0);
        gen(T_ADDIU, 6'h00, 1'b0, 0, 0, 1'b0, 0);
        gen(T_SLTI,  6'h00, 1'b0, 0, 0, 1'b1, 0);
        gen(T_ANDI,  6'h00, 1'b0, 0, 0, 1'b0, 0);
        gen(T_ORI,   6'h00, 1'b0, 0, 0, 1'b1, 0);
        gen(T_XORI,  6'h00, 1'b0, 0, 0, 1'b0, 0);
        gen(T_BEQ,   6'h00, 1'b0, 0, 0, 1'b1, 0);
        gen(T_BNE,   6'h00, 1'b0, 0, 0, 1'b1, 0);
        gen(T_J,     6'h00, 1'b0, 1, 0, 1'b1, 0);
        gen(T_R,     6'h08, 1'b0, 0, 0, 1'b1, 0);
        gen(T_LW,    6'h00, 1'b0, 0, 0, 1'b1, 0);
        gen(T_SW,    6'h00, 1'b0, 0, 0, 1'b0, 0);
        run("mix", -1);

        gen(T_R, 6'h21, 1'b0, 0, 0, 1'b1, 6);
        run("badfn", -1);
        check_int("badfn_halt", obs[7].halt, 1);
        do_reset();

        gen(6'h3F, 6'h20, 1'b0, 0, 0, 1'b1, 10);
        run("trap", -1);
        n = 0;
        for (int i = 2; i < obs.size(); i++) if (obs[i].halt && !obs[i].mem_req) n++;
        check_int("trap_halt10", n, 10);
        do_reset();

        gen(T_SW, 6'h00, 1'b0, 0, 5, 1'b0, 0);
        run("swrst", 5);
        check_int("swrst_pre", {obs[4].mem_req, obs[4].mem_we}, 3);
        #2 rst_n = 1'b0;
        #1 check_int("swrst_req", {mem_req, mem_we}, 0);
        check_vec("swrst_all", '0);
        release_rst("swrst_rel");
        gen(T_R, 6'h20, 1'b0, 0, 0, 1'b0, 0);
        run("after_rst", -1);

`ifdef MC_CTRL_PERF_EN
        do_reset();
        for (int i = 0; i < 20; i++) gen(T_R, 6'h20, 1'b0, 0, 0, 1'b0, 0);
        run("perf", -1);
        @(posedge clk); #1;
        check_int("perf_instr", instr_cnt, 4);
        check_int("perf_cyc", cyc_cnt, 0);
        @(posedge clk); #1;
        check_int("perf_cyc_next", cyc_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
